ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical ps2_clk samples needed to accept a level change.
REQ-002 Parameter TIMEOUT, default 5000: clk cycles without a ps2_clk falling edge mid-frame before the frame is abandoned.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous.
REQ-007 out  output  16  Hack keyboard code for the memory-mapped keyboard register; 0 when no key is held.
REQ-008 key_event  output  1  one-cycle pulse whenever out changes value.
REQ-009 frame_error  output  1  one-cycle pulse on any discarded frame (parity, start, stop or timeout).

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; ps2_clk SHALL then pass through the FILTER_LEN glitch filter.
REQ-011 Falling edge = filtered ps2_clk 1->0; ps2_data is sampled on that cycle.
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP; IDLE->DATA on a falling edge with data=0; a falling edge with data=1 in IDLE is ignored.
REQ-013 DATA collects 8 bits LSB first, then goes to PARITY; PARITY checks odd parity over 8 data bits plus the parity bit; STOP requires data=1.
REQ-014 On a valid stop bit, the byte SHALL be handed to the decoder in the same cycle and the FSM SHALL return to IDLE.
REQ-015 Bad parity or bad stop: drop the byte, pulse frame_error, return to IDLE.
REQ-016 In any state other than IDLE, TIMEOUT cycles without a falling edge: drop the frame, pulse frame_error, return to IDLE.
REQ-017 Decoder flags: brk set by 0xF0, ext set by 0xE0; both flags clear after the next non-prefix byte.
REQ-018 Make of a mapped key: out <= code on the cycle after the stop bit is sampled (latency 1).
REQ-019 Break of a mapped key whose code equals out: out <= 0; break of any other key leaves out unchanged.
REQ-020 A repeated make (typematic) of the same key leaves out unchanged and raises no key_event.
REQ-021 A new make while another key is held replaces out; the older key's later break has no effect.
REQ-022 Mapping: letters -> 65..90; digits -> 48..57; space 32; printable punctuation -> ASCII.
REQ-023 Special-key mapping: Enter 128, Backspace 129, Left 130, Up 131, Right 132, Down 133, Home 134, End 135, PgUp 136, PgDn 137, Insert 138, Delete 139, Esc 140, F1..F12 141..152.
REQ-024 Arrows, Home, End, PgUp, PgDn, Insert and Delete SHALL map only when ext=1; unmapped scancodes are ignored.
REQ-025 out[15:8] SHALL always be 0.

Reset
REQ-026 reset SHALL force: FSM to IDLE, bit counter 0, brk=0, ext=0, shift state 0, out=0, key_event=0, frame_error=0, synchronisers and filter to 1 (idle line).
REQ-027 Reset mid-frame discards the partial frame; the next frame decodes normally.

Configuration
REQ-028 With KEYBOARD_SHIFT_EN defined, the block tracks Left Shift (0x12) and Right Shift (0x59) make/break; shift keys never change out.
REQ-029 With KEYBOARD_SHIFT_EN defined: unshifted letters map to 97..122, shifted letters to 65..90; shifted digits and punctuation give US-layout symbols (for example Shift+2 = 64).
REQ-030 Without KEYBOARD_SHIFT_EN: no shift logic is present, shift scancodes are ignored, letters are always 65..90, digits and punctuation are unshifted.

Verification
REQ-031 Frame 0x1C, then F0 1C (no macro) -> out=65 one cycle after the first stop bit with a key_event pulse, then out=0 after the release.
REQ-032 E0 75 -> out=131; then E0 F0 75 -> out=0; plain 0x75 (keypad 8, unmapped) -> out unchanged.
REQ-033 Frame 0x5A with wrong parity -> frame_error pulse, out stays 0; the next valid 0x5A frame -> out=128.
REQ-034 Start bit followed by 4 data bits, then silence -> frame_error after TIMEOUT cycles; a following valid 0x76 frame -> out=140.
REQ-035 With macro: 12, 1C, F0 1C, F0 12, 1C -> out 0, 65, 0, 0, 97.
REQ-036 Hold 0x1C, make 0x32, break 0x1C -> out=65, then 66, then still 66; reset asserted mid-frame -> out=0 and FSM in IDLE.

Source files
------------

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 set-2 keyboard receiver driving a Hack keyboard register.
// Define KEYBOARD_SHIFT_EN to track the shift keys and emit lowercase letters and shifted symbols.
module ps2_keyboard #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] out,
  output logic        key_event,
  output logic        frame_error
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            csync_q, dsync_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  fclk_q, fclk_dly_q;
  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [7:0]            sreg_q, sreg_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  brk_q, brk_d, ext_q, ext_d;
  logic [7:0]            out_q, out_d;
  logic                  key_event_q, frame_error_q;
  logic                  fall, din, byte_valid, ferr;
  logic [7:0]            code;
`ifdef KEYBOARD_SHIFT_EN
  logic                  shift_q, shift_d;
`endif

  assign fall        = fclk_dly_q & ~fclk_q;
  assign din         = dsync_q[1];
  assign out         = {8'd0, out_q};
  assign key_event   = key_event_q;
  assign frame_error = frame_error_q;

  // Base (unshifted, uppercase) code for a scancode; 0 means unmapped.
  function automatic logic [7:0] map_key(input logic [7:0] sc, input logic e);
    logic [7:0] k;
    k = 8'd0;
    if (e) begin
      case (sc)
        8'h6B: k = 8'd130;  8'h75: k = 8'd131;  8'h74: k = 8'd132;  8'h72: k = 8'd133;
        8'h6C: k = 8'd134;  8'h69: k = 8'd135;  8'h7D: k = 8'd136;  8'h7A: k = 8'd137;
        8'h70: k = 8'd138;  8'h71: k = 8'd139;
        default: k = 8'd0;
      endcase
    end else begin
      case (sc)
        8'h1C: k = 8'd65;  8'h32: k = 8'd66;  8'h21: k = 8'd67;  8'h23: k = 8'd68;
        8'h24: k = 8'd69;  8'h2B: k = 8'd70;  8'h34: k = 8'd71;  8'h33: k = 8'd72;
        8'h43: k = 8'd73;  8'h3B: k = 8'd74;  8'h42: k = 8'd75;  8'h4B: k = 8'd76;
        8'h3A: k = 8'd77;  8'h31: k = 8'd78;  8'h44: k = 8'd79;  8'h4D: k = 8'd80;
        8'h15: k = 8'd81;  8'h2D: k = 8'd82;  8'h1B: k = 8'd83;  8'h2C: k = 8'd84;
        8'h3C: k = 8'd85;  8'h2A: k = 8'd86;  8'h1D: k = 8'd87;  8'h22: k = 8'd88;
        8'h35: k = 8'd89;  8'h1A: k = 8'd90;
        8'h45: k = 8'd48;  8'h16: k = 8'd49;  8'h1E: k = 8'd50;  8'h26: k = 8'd51;
        8'h25: k = 8'd52;  8'h2E: k = 8'd53;  8'h36: k = 8'd54;  8'h3D: k = 8'd55;
        8'h3E: k = 8'd56;  8'h46: k = 8'd57;  8'h29: k = 8'd32;
        8'h0E: k = 8'd96;  8'h4E: k = 8'd45;  8'h55: k = 8'd61;  8'h54: k = 8'd91;
        8'h5B: k = 8'd93;  8'h5D: k = 8'd92;  8'h4C: k = 8'd59;  8'h52: k = 8'd39;
        8'h41: k = 8'd44;  8'h49: k = 8'd46;  8'h4A: k = 8'd47;
        8'h5A: k = 8'd128; 8'h66: k = 8'd129; 8'h76: k = 8'd140;
        8'h05: k = 8'd141; 8'h06: k = 8'd142; 8'h04: k = 8'd143; 8'h0C: k = 8'd144;
        8'h03: k = 8'd145; 8'h0B: k = 8'd146; 8'h83: k = 8'd147; 8'h0A: k = 8'd148;
        8'h01: k = 8'd149; 8'h09: k = 8'd150; 8'h78: k = 8'd151; 8'h07: k = 8'd152;
        default: k = 8'd0;
      endcase
    end
    return k;
  endfunction

  // Frame receiver; timeout counts cycles since the last falling edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sreg_d     = sreg_q;
    tmo_d      = (state_q != IDLE && !fall) ? tmo_q + TW'(1) : '0;
    byte_valid = 1'b0;
    ferr       = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d = DATA;
          cnt_d   = 3'd0;
        end
        DATA: begin
          sreg_d = {din, sreg_q[7:1]};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: if (^{sreg_q, din}) state_d = STOP;
                else begin
                  ferr    = 1'b1;
                  state_d = IDLE;
                end
        STOP: begin
          state_d = IDLE;
          if (din) byte_valid = 1'b1;
          else     ferr       = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
      ferr    = 1'b1;
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

  always_comb begin
    out_d = out_q;
    brk_d = brk_q;
    ext_d = ext_q;
    code  = map_key(sreg_q, ext_q);
`ifdef KEYBOARD_SHIFT_EN
    shift_d = shift_q;
    if (code >= 8'd65 && code <= 8'd90) begin
      if (!shift_q) code = code + 8'd32;
    end else if (shift_q && !ext_q) begin
      case (code)
        8'd49: code = 8'd33;  8'd50: code = 8'd64;  8'd51: code = 8'd35;  8'd52: code = 8'd36;
        8'd53: code = 8'd37;  8'd54: code = 8'd94;  8'd55: code = 8'd38;  8'd56: code = 8'd42;
        8'd57: code = 8'd40;  8'd48: code = 8'd41;  8'd96: code = 8'd126; 8'd45: code = 8'd95;
        8'd61: code = 8'd43;  8'd91: code = 8'd123; 8'd93: code = 8'd125; 8'd92: code = 8'd124;
        8'd59: code = 8'd58;  8'd39: code = 8'd34;  8'd44: code = 8'd60;  8'd46: code = 8'd62;
        8'd47: code = 8'd63;
        default: code = code;
      endcase
    end
`endif
    if (byte_valid) begin
      if (sreg_q == 8'hF0) brk_d = 1'b1;
      else if (sreg_q == 8'hE0) ext_d = 1'b1;
      else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
`ifdef KEYBOARD_SHIFT_EN
        if (!ext_q && (sreg_q == 8'h12 || sreg_q == 8'h59)) shift_d = !brk_q;
`endif
        // A break only clears out when it names the key currently shown.
        if (code != 8'd0) begin
          if (!brk_q)             out_d = code;
          else if (code == out_q) out_d = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csync_q       <= 2'b11;
      dsync_q       <= 2'b11;
      filt_q        <= '1;
      fclk_q        <= 1'b1;
      fclk_dly_q    <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      sreg_q        <= 8'd0;
      tmo_q         <= '0;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      out_q         <= 8'd0;
      key_event_q   <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef KEYBOARD_SHIFT_EN
      shift_q       <= 1'b0;
`endif
    end else begin
      csync_q       <= {csync_q[0], ps2_clk};
      dsync_q       <= {dsync_q[0], ps2_data};
      filt_q        <= {filt_q[FILTER_LEN-2:0], csync_q[1]};
      if (&filt_q)       fclk_q <= 1'b1;
      else if (~|filt_q) fclk_q <= 1'b0;
      fclk_dly_q    <= fclk_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sreg_q        <= sreg_d;
      tmo_q         <= tmo_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      out_q         <= out_d;
      key_event_q   <= (out_d != out_q);
      frame_error_q <= ferr;
`ifdef KEYBOARD_SHIFT_EN
      shift_q       <= shift_d;
`endif
    end
  end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - scoreboard bench for ps2_keyboard with a table-driven key model.
module tb_ps2_keyboard;
  localparam int FLEN = 8;
  localparam int TMO  = 200;
  localparam int H    = 20;
`ifdef KEYBOARD_SHIFT_EN
  localparam logic [15:0] A_VAL = 16'd97;
  localparam logic [15:0] B_VAL = 16'd98;
`else
  localparam logic [15:0] A_VAL = 16'd65;
  localparam logic [15:0] B_VAL = 16'd66;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] out;
  logic        key_event, frame_error;

  always #5 clk = ~clk;

  ps2_keyboard #(.FILTER_LEN(FLEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out(out), .key_event(key_event), .frame_error(frame_error)
  );

  typedef struct {bit is_err; logic [15:0] val;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int base_map[logic [7:0]];
  int shift_map[logic [7:0]];
  int ext_map[logic [7:0]];
  logic [8:0] pool[$];

  bit m_brk, m_ext, m_shift;
  logic [15:0] m_out;

  logic [7:0] let_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                             8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                             8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_sc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  int dig_sh[10] = '{41, 33, 64, 35, 36, 37, 94, 38, 42, 40};
  logic [7:0] pun_sc[11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  int pun_asc[11] = '{96, 45, 61, 91, 93, 92, 59, 39, 44, 46, 47};
  int pun_sh[11]  = '{126, 95, 43, 123, 125, 124, 58, 34, 60, 62, 63};
  logic [7:0] fn_sc[12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
  logic [7:0] ex_sc[10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

  task automatic push(input bit is_err, input logic [15:0] val);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shift = 0; m_out = 16'd0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int v;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      v = 0;
      if (m_ext) begin
        if (ext_map.exists(b)) v = ext_map[b];
      end else if (base_map.exists(b)) begin
        v = base_map[b];
`ifdef KEYBOARD_SHIFT_EN
        if (v >= 65 && v <= 90) begin
          if (!m_shift) v = v + 32;
        end else if (m_shift && shift_map.exists(b)) v = shift_map[b];
`endif
      end
`ifdef KEYBOARD_SHIFT_EN
      if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = !m_brk;
`endif
      if (v != 0) begin
        if (m_brk) begin
          if (v == int'(m_out)) begin m_out = 16'd0; push(0, 16'd0); end
        end else if (v != int'(m_out)) begin
          m_out = 16'(v);
          push(0, m_out);
        end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = ~(^b) ^ bad;
    if (bad) push(1, 16'd0);
    else     model_byte(b);
    send_bits({1'b1, par, b, 1'b0}, 11);
  endtask

  task automatic send_key(input bit e, input bit brk, input logic [7:0] sc, input bit bad);
    if (e)   send_frame(8'hE0, 0);
    if (brk) send_frame(8'hF0, 0);
    send_frame(sc, bad);
  endtask

  // Monitor: every output pulse is matched against the oldest expectation.
  logic [15:0] prev_out = 16'd0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (key_event) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL key_event: unexpected pulse, out=%0d", out);
          end else begin
            e = exp_q.pop_front();
            if (e.is_err || out !== e.val) begin
              errors++;
              $display("FAIL key_event: got out=%0d expected %s %0d", out,
                       e.is_err ? "frame_error" : "out", e.val);
            end
          end
        end
        if (frame_error) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_error: unexpected pulse");
          end else begin
            e = exp_q.pop_front();
            if (!e.is_err) begin
              errors++;
              $display("FAIL frame_error: got frame_error expected out %0d", e.val);
            end
          end
        end
        if (out !== prev_out && !key_event) begin
          checks++;
          errors++;
          $display("FAIL silent_change: out %0d -> %0d without key_event", prev_out, out);
        end
      end
      prev_out = out;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [8:0] p;
    bit brk, bad;
    for (int i = 0; i < 26; i++) base_map[let_sc[i]] = 65 + i;
    for (int i = 0; i < 10; i++) begin base_map[dig_sc[i]] = 48 + i; shift_map[dig_sc[i]] = dig_sh[i]; end
    for (int i = 0; i < 11; i++) begin base_map[pun_sc[i]] = pun_asc[i]; shift_map[pun_sc[i]] = pun_sh[i]; end
    for (int i = 0; i < 12; i++) base_map[fn_sc[i]] = 141 + i;
    for (int i = 0; i < 10; i++) ext_map[ex_sc[i]] = 130 + i;
    base_map[8'h29] = 32;  base_map[8'h5A] = 128;
    base_map[8'h66] = 129; base_map[8'h76] = 140;
    foreach (base_map[k]) pool.push_back({1'b0, k});
    foreach (ext_map[k])  pool.push_back({1'b1, k});
    pool.push_back({1'b0, 8'h75}); pool.push_back({1'b0, 8'h12});
    pool.push_back({1'b0, 8'h59}); pool.push_back({1'b1, 8'h5A});
    model_reset();

    repeat (5) @(negedge clk);
    check("reset_out", out, 16'd0);
    check("reset_key_event", 16'(key_event), 16'd0);
    check("reset_frame_error", 16'(frame_error), 16'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    send_key(0, 0, 8'h1C, 0);  check("make_A", out, A_VAL);
    send_key(0, 1, 8'h1C, 0);  check("break_A", out, 16'd0);

    send_key(1, 0, 8'h75, 0);  check("ext_up", out, 16'd131);
    send_key(0, 0, 8'h75, 0);  check("keypad8_ignored", out, 16'd131);
    send_key(1, 1, 8'h75, 0);  check("ext_up_break", out, 16'd0);

    send_key(0, 0, 8'h5A, 1);  check("bad_parity_enter", out, 16'd0);
    send_key(0, 0, 8'h5A, 0);  check("enter", out, 16'd128);
    send_key(0, 1, 8'h5A, 0);  check("enter_break", out, 16'd0);

    push(1, 16'd0);
    send_bits({1'b0, ~(^8'h1C), 8'h1C, 1'b0}, 11);
    check("bad_stop", out, 16'd0);

    push(1, 16'd0);
    send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 5);
    repeat (TMO + 60) @(negedge clk);
    check("timeout_queue_drained", 16'(exp_q.size()), 16'd0);
    send_key(0, 0, 8'h76, 0);  check("esc_after_timeout", out, 16'd140);
    send_key(0, 0, 8'h76, 0);  check("typematic_esc", out, 16'd140);
    send_key(0, 1, 8'h76, 0);  check("esc_break", out, 16'd0);

    send_key(0, 0, 8'h1C, 0);  check("hold_A", out, A_VAL);
    send_key(0, 0, 8'h32, 0);  check("replace_B", out, B_VAL);
    send_key(0, 1, 8'h1C, 0);  check("stale_break_A", out, B_VAL);
    send_bits({1'b1, 1'b0, 8'h3C, 1'b0}, 5);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    check("reset_mid_frame_out", out, 16'd0);
    check("reset_mid_frame_queue", 16'(exp_q.size()), 16'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send_key(0, 0, 8'h1C, 0);  check("make_after_reset", out, A_VAL);
    send_key(0, 1, 8'h1C, 0);  check("break_after_reset", out, 16'd0);

`ifdef KEYBOARD_SHIFT_EN
    send_key(0, 0, 8'h12, 0);  check("shift_make", out, 16'd0);
    send_key(0, 0, 8'h1C, 0);  check("shift_A", out, 16'd65);
    send_key(0, 1, 8'h1C, 0);  check("shift_A_break", out, 16'd0);
    send_key(0, 1, 8'h12, 0);  check("shift_break", out, 16'd0);
    send_key(0, 0, 8'h1C, 0);  check("lower_a", out, 16'd97);
    send_key(0, 1, 8'h1C, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      p   = pool[$urandom_range(pool.size() - 1)];
      brk = ($urandom_range(2) == 0);
      bad = ($urandom_range(9) == 0);
      send_key(p[8], brk, p[7:0], bad);
      check("random_out", out, m_out);
    end

    repeat (TMO + 50) @(negedge clk);
    check("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
